// File: rtl/blk_sched.sv
// Block-timing scheduler: tracks vsync/de, splits each frame into an HBLKS x VBLKS grid
// of BLKW x BLKH pixel blocks, emits block strobes aligned with the 1-cycle pixel pipeline.
module blk_sched #(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int BLKW  = 30,
    parameter int BLKH  = 30,
    localparam int XW   = $clog2(HBLKS + 1),
    localparam int YW   = $clog2(VBLKS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vs_i,
    input  logic          hs_i,
    input  logic          de_i,
    input  logic [23:0]   wd_i,
    output logic          de_o,
    output logic [23:0]   wd_o,
    output logic          h_save_o,
    output logic          v_save_o,
    output logic [XW-1:0] blk_x_o,
    output logic [YW-1:0] blk_y_o,
    output logic          frame_ok_o,
    output logic          err_o
);

    localparam int PXW = $clog2(BLKW + 1);
    localparam int LNW = $clog2(BLKH + 1);

    localparam logic [PXW-1:0] PX_LAST = PXW'(BLKW - 1);
    localparam logic [LNW-1:0] LN_LAST = LNW'(BLKH - 1);
    localparam logic [XW-1:0]  BX_MAX  = XW'(HBLKS);
    localparam logic [YW-1:0]  BY_MAX  = YW'(VBLKS);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        LGAP
    } state_t;

    state_t         state_q, state_d;
    logic           vs_q, de_q;
    logic [PXW-1:0] px_q, px_d;
    logic [XW-1:0]  bx_q, bx_d;
    logic [LNW-1:0] ln_q, ln_d;
    logic [YW-1:0]  by_q, by_d;
    logic           h_save_d, v_save_d, frame_ok_d, err_d;
    logic           count_px;
    logic           vs_rise, de_rise;

    // Line ends are taken from the de fall; hsync carries no extra timing here.
    logic unused_hs;
    assign unused_hs = hs_i;

    assign vs_rise = vs_i & ~vs_q;
    assign de_rise = de_i & ~de_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        px_d       = px_q;
        bx_d       = bx_q;
        ln_d       = ln_q;
        by_d       = by_q;
        h_save_d   = 1'b0;
        v_save_d   = 1'b0;
        frame_ok_d = 1'b0;
        err_d      = err_o;
        count_px   = 1'b0;

        if (vs_rise) begin
            // Frame end: a pixel coincident with vsync is never counted and always an error.
            if (state_q != IDLE) begin
                if (by_q == BY_MAX && ln_q == '0 && !err_o && !de_i) frame_ok_d = 1'b1;
                else                                                  err_d      = 1'b1;
            end
            if (de_i) err_d = 1'b1;
            px_d    = '0;
            bx_d    = '0;
            ln_d    = '0;
            by_d    = '0;
            state_d = SYNC;
        end else begin
            case (state_q)
                SYNC, LGAP: begin
                    if (de_rise) begin
                        state_d  = ACTIVE;
                        count_px = 1'b1;
                        v_save_d = (ln_q == '0) && (by_q < BY_MAX);
                    end
                end
                ACTIVE: begin
                    if (de_i) begin
                        count_px = 1'b1;
                    end else begin
                        state_d = LGAP;
                        if (!(bx_q == BX_MAX && px_q == '0)) err_d = 1'b1;
                        px_d = '0;
                        bx_d = '0;
                        if (ln_q == LN_LAST) begin
                            ln_d = '0;
                            if (by_q < BY_MAX) by_d = by_q + 1'b1;
                        end else begin
                            ln_d = ln_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Pixels outside the grid pass through untouched but flag the frame.
            if (count_px) begin
                if (bx_q < BX_MAX && by_q < BY_MAX) begin
                    if (px_q == PX_LAST) begin
                        h_save_d = 1'b1;
                        px_d     = '0;
                        bx_d     = bx_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            px_q       <= '0;
            bx_q       <= '0;
            ln_q       <= '0;
            by_q       <= '0;
            de_o       <= 1'b0;
            wd_o       <= '0;
            h_save_o   <= 1'b0;
            v_save_o   <= 1'b0;
            blk_x_o    <= '0;
            blk_y_o    <= '0;
            frame_ok_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            vs_q       <= vs_i;
            de_q       <= de_i;
            px_q       <= px_d;
            bx_q       <= bx_d;
            ln_q       <= ln_d;
            by_q       <= by_d;
            de_o       <= de_i;
            wd_o       <= wd_i;
            h_save_o   <= h_save_d;
            v_save_o   <= v_save_d;
            blk_x_o    <= bx_q;
            blk_y_o    <= by_q;
            frame_ok_o <= frame_ok_d;
            err_o      <= err_d;
        end
    end

endmodule
